id_issue_stage: RTL and testbench
=================================

# id_issue_stage

Parametrised successor to the current decode front end. It holds the IF→ID pipeline register and captures the instruction word across stalls so it is not lost when `inst_sram_rdata` moves on. It resolves both source operands through an N-deep forwarding network and raises a load-use stall request. A saturating stall-cycle counter is included for performance measurement. It sits between IF (PC bus, instruction SRAM read data) and the decode/EX logic, replacing the bare pipeline register and regfile-side forwarding.

## Interface
Parameters:
- `XLEN`, 32, data/PC width
- `RA_W`, 5, register address width
- `NUM_FWD`, 3, forwarding sources; index 0 = youngest (EX), ascending = older (MEM, WB)
- `STALL_W`, 6, stall bus width; bit 1 = IF stop, bit 2 = ID stop
- `CNT_W`, 16, stall counter width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `stall`  in  STALL_W  pipeline stall bus
- `if_ce`  in  1  IF slot valid
- `if_pc`  in  XLEN  IF PC
- `inst_sram_rdata`  in  32  instruction for the PC currently held in ID
- `rf_raddr1`, `rf_raddr2`  out  RA_W  regfile read addresses (inst[25:21], inst[20:16] of `id_inst`)
- `rf_rdata1`, `rf_rdata2`  in  XLEN  regfile read data
- `fwd_we`  in  NUM_FWD  per-source write enable
- `fwd_waddr`  in  NUM_FWD*RA_W  per-source destination, source k at [k*RA_W +: RA_W]
- `fwd_wdata`  in  NUM_FWD*XLEN  per-source result
- `fwd_pend`  in  NUM_FWD  result not yet available (load in flight)
- `cnt_clr`  in  1  synchronous clear of stall counter
- `id_valid`  out  1  ID slot holds a real instruction
- `id_pc`  out  XLEN  PC of ID slot
- `id_inst`  out  32  instruction of ID slot; 0 (NOP) when invalid
- `src1`, `src2`  out  XLEN  resolved rs / rt operands
- `stallreq`  out  1  load-use interlock request
- `stall_cnt`  out  CNT_W  cycles with `stallreq`=1

## Operation
- ID register `{valid, pc}`, priority order:
  1. `stall[1]`=1 and `stall[2]`=0: load bubble (valid=0, pc=0).
  2. `stall[1]`=0: load `{if_ce, if_pc}`.
  3. Otherwise: hold.
- Instruction hold FSM, states PASS / HOLD:
  - PASS: `id_inst` = valid ? `inst_sram_rdata` : 0. If `stall[2]`=1 and valid: capture `inst_sram_rdata` into `inst_buf`, go to HOLD.
  - HOLD: `id_inst` = `inst_buf`. When `stall[2]`=0, return to PASS. The buffered word is consumed that same cycle.
  - A bubble load (rule 1) forces PASS and zeroes `inst_buf`.
- Operand select, per source, with `a` = rs or rt:
  - `a`=0 → 0.
  - Else take the lowest k with `fwd_we[k]` and `fwd_waddr[k]`=`a` → `fwd_wdata[k]`.
  - Else the regfile data.
  - Older matching sources are ignored once a younger one matches.
- `stallreq` = `id_valid` & (the winning source for rs or rt has `fwd_pend`=1). Both sources are checked unconditionally (conservative). A pending match at an older k that is masked by a younger non-pending match does not stall.
- `stall_cnt`:
  - Increments when `stallreq`=1.
  - Saturates at all-ones.
  - `cnt_clr` has priority over increment.

## Timing
- Reset values: `id_valid`=0, `id_pc`=0, `id_inst`=0, FSM=PASS, `inst_buf`=0, `stall_cnt`=0. `src1`, `src2` and `stallreq` follow from the invalid slot (`stallreq`=0).
- `id_valid` and `id_pc` are registered, available one cycle after IF.
- `id_inst`, `src1`, `src2` and `stallreq` are combinational from current inputs and state, valid in the same cycle. There is no registered path from `fwd_*` to outputs.
- HOLD entry takes effect from the cycle after `stall[2]` rises. The capture edge is the first stalled clock.
- Reset mid-stall: immediate return to reset values, with no edge needed.
- Simultaneous `stall[1]`=1, `stall[2]`=1: hold the register; the FSM stays in or enters HOLD.

## Structure
- Package `id_pkg`: stall bit indices (`STALL_IF`=1, `STALL_ID`=2), `INST_NOP`=32'h0, FSM state enum, default parameter constants.
- Sub-module `fwd_select`: parametrised by `NUM_FWD`, `XLEN`, `RA_W`. Inputs: address, regfile data, `fwd_*` buses. Outputs: operand and pending flag. Instantiated twice (rs, rt).

## Test plan
- Reset then `if_ce`=1, `if_pc`=0xBFC00000, rdata 0x3C011234 → next cycle `id_valid`=1, `id_pc`=0xBFC00000, `id_inst`=0x3C011234.
- Stall capture: hold `stall[2]`=1 for 3 cycles while rdata changes to 0xDEADBEEF → `id_inst` stays at the first word; after release, one cycle with the original word, then a new PC loads.
- Forwarding priority: rs=5, sources 0 and 2 both write r5 with 0x11 and 0x33 → `src1`=0x11. With source 0 disabled → 0x33. rs=0 with all sources writing r0 → 0.
- Load-use: source 0 matches rt with `fwd_pend`=1 → `stallreq`=1 and `stall_cnt` increments. The same match with pend on older source 1 only → `stallreq`=0.
- Bubble: `stall[1]`=1, `stall[2]`=0 → next cycle `id_valid`=0, `id_inst`=0, `stallreq`=0 regardless of `fwd_*`.
- Counter: CNT_W=4, 20 stall cycles → `stall_cnt`=0xF. `cnt_clr` in the same cycle as `stallreq` → 0. Async `rst` mid-HOLD → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/id_pkg.sv
// Shared constants and types for the ID issue stage: stall bus bit positions,
// the NOP encoding, the instruction-hold state enum and default parameter values.
package id_pkg;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

  localparam logic [31:0] INST_NOP = 32'h0;

  localparam int XLEN_DEF    = 32;
  localparam int RA_W_DEF    = 5;
  localparam int NUM_FWD_DEF = 3;
  localparam int STALL_W_DEF = 6;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_e;
endpackage

// File: rtl/fwd_select.sv
// One operand port of the forwarding network: the youngest matching writer wins,
// r0 always reads zero, and the winner's pending flag is reported for interlocking.
module fwd_select
  import id_pkg::*;
#(
  parameter int NUM_FWD = NUM_FWD_DEF,
  parameter int XLEN    = XLEN_DEF,
  parameter int RA_W    = RA_W_DEF
) (
  input  logic [RA_W-1:0]         addr,
  input  logic [XLEN-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [NUM_FWD*RA_W-1:0] fwd_waddr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]      fwd_pend,
  output logic [XLEN-1:0]         operand,
  output logic                    pend
);

  logic found;

  always_comb begin
    operand = rf_data;
    pend    = 1'b0;
    found   = 1'b0;
    if (addr == '0) begin
      operand = '0;
    end else begin
      // Ascending scan; the first hit blocks every older source.
      for (int k = 0; k < NUM_FWD; k++) begin
        if (!found && fwd_we[k] && (fwd_waddr[k*RA_W +: RA_W] == addr)) begin
          found   = 1'b1;
          operand = fwd_wdata[k*XLEN +: XLEN];
          pend    = fwd_pend[k];
        end
      end
    end
  end

endmodule

// File: rtl/id_issue_stage.sv
// IF->ID pipeline register with stall-safe instruction capture, two-port operand
// forwarding, load-use interlock request and a saturating stall-cycle counter.
module id_issue_stage
  import id_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RA_W    = RA_W_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF,
  parameter int STALL_W = STALL_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic                    if_ce,
  input  logic [XLEN-1:0]         if_pc,
  input  logic [31:0]             inst_sram_rdata,
  output logic [RA_W-1:0]         rf_raddr1,
  output logic [RA_W-1:0]         rf_raddr2,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [NUM_FWD*RA_W-1:0] fwd_waddr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]      fwd_pend,
  input  logic                    cnt_clr,
  output logic                    id_valid,
  output logic [XLEN-1:0]         id_pc,
  output logic [31:0]             id_inst,
  output logic [XLEN-1:0]         src1,
  output logic [XLEN-1:0]         src2,
  output logic                    stallreq,
  output logic [CNT_W-1:0]        stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic            valid_p1;
  logic [XLEN-1:0] pc_p1;
  hold_state_e     state;
  logic [31:0]     inst_buf;
  logic            bubble;
  logic            load;
  logic            pend1;
  logic            pend2;
  logic            unused_stall_bits;

  assign bubble            = stall[STALL_IF] & ~stall[STALL_ID];
  assign load              = ~stall[STALL_IF];
  assign unused_stall_bits = ^{stall[STALL_W-1:STALL_ID+1], stall[0]};

  // IF -> ID boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_p1 <= 1'b0;
      pc_p1    <= '0;
    end else if (bubble) begin
      valid_p1 <= 1'b0;
      pc_p1    <= '0;
    end else if (load) begin
      valid_p1 <= if_ce;
      pc_p1    <= if_pc;
    end
  end

  // The SRAM word tracks the PC presented a cycle earlier, so it is latched on
  // the first stalled edge and replayed until the ID stop drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_PASS;
      inst_buf <= INST_NOP;
    end else if (bubble) begin
      state    <= ST_PASS;
      inst_buf <= INST_NOP;
    end else begin
      case (state)
        ST_PASS: begin
          if (stall[STALL_ID] && valid_p1) begin
            inst_buf <= inst_sram_rdata;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!stall[STALL_ID]) state <= ST_PASS;
        end
        default: state <= ST_PASS;
      endcase
    end
  end

  always_comb begin
    id_inst = INST_NOP;
    if (state == ST_HOLD) id_inst = inst_buf;
    else if (valid_p1)    id_inst = inst_sram_rdata;
  end

  assign id_valid  = valid_p1;
  assign id_pc     = pc_p1;
  assign rf_raddr1 = RA_W'(id_inst[25:21]);
  assign rf_raddr2 = RA_W'(id_inst[20:16]);

  fwd_select #(.NUM_FWD(NUM_FWD), .XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs (
    .addr      (rf_raddr1),
    .rf_data   (rf_rdata1),
    .fwd_we    (fwd_we),
    .fwd_waddr (fwd_waddr),
    .fwd_wdata (fwd_wdata),
    .fwd_pend  (fwd_pend),
    .operand   (src1),
    .pend      (pend1)
  );

  fwd_select #(.NUM_FWD(NUM_FWD), .XLEN(XLEN), .RA_W(RA_W)) u_fwd_rt (
    .addr      (rf_raddr2),
    .rf_data   (rf_rdata2),
    .fwd_we    (fwd_we),
    .fwd_waddr (fwd_waddr),
    .fwd_wdata (fwd_wdata),
    .fwd_pend  (fwd_pend),
    .operand   (src2),
    .pend      (pend2)
  );

  assign stallreq = valid_p1 & (pend1 | pend2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           stall_cnt <= '0;
    else if (cnt_clr)  stall_cnt <= '0;
    else if (stallreq) stall_cnt <= sat_inc(stall_cnt);
  end

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_id_issue_stage;
  localparam int XLEN    = 32;
  localparam int RA_W    = 5;
  localparam int NUM_FWD = 3;
  localparam int STALL_W = 6;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [STALL_W-1:0]      stall = '0;
  logic                    if_ce = 1'b0;
  logic [XLEN-1:0]         if_pc = '0;
  logic [31:0]             inst_sram_rdata = '0;
  logic [RA_W-1:0]         rf_raddr1, rf_raddr2;
  logic [XLEN-1:0]         rf_rdata1 = '0, rf_rdata2 = '0;
  logic [NUM_FWD-1:0]      fwd_we = '0;
  logic [NUM_FWD*RA_W-1:0] fwd_waddr = '0;
  logic [NUM_FWD*XLEN-1:0] fwd_wdata = '0;
  logic [NUM_FWD-1:0]      fwd_pend = '0;
  logic                    cnt_clr = 1'b0;
  logic                    id_valid;
  logic [XLEN-1:0]         id_pc;
  logic [31:0]             id_inst;
  logic [XLEN-1:0]         src1, src2;
  logic                    stallreq;
  logic [CNT_W-1:0]        stall_cnt;

  int checks = 0;
  int failures = 0;

  id_issue_stage #(.XLEN(XLEN), .RA_W(RA_W), .NUM_FWD(NUM_FWD),
                   .STALL_W(STALL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .if_ce(if_ce), .if_pc(if_pc),
    .inst_sram_rdata(inst_sram_rdata), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_we(fwd_we),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pend(fwd_pend),
    .cnt_clr(cnt_clr), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .src1(src1), .src2(src2), .stallreq(stallreq), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: slot contents, the word frozen at the start of a stall run,
  // and the stall-cycle count as a plain integer.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0;
  logic        m_frozen = 1'b0;
  logic [31:0] m_word = '0;
  int          m_cnt = 0;
  logic        m_sr;

  function automatic void model_reset();
    m_valid = 1'b0; m_pc = '0; m_frozen = 1'b0; m_word = '0; m_cnt = 0;
  endfunction

  function automatic logic [31:0] m_inst();
    if (m_frozen) return m_word;
    return m_valid ? inst_sram_rdata : 32'h0;
  endfunction

  // Older writers are visited first so the youngest match overwrites them.
  function automatic void m_resolve(input logic [4:0] a, input logic [31:0] rf,
                                    output logic [31:0] v, output logic p);
    v = rf;
    p = 1'b0;
    if (a == 5'd0) begin
      v = '0;
      return;
    end
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_we[k] && fwd_waddr[k*RA_W +: RA_W] == a) begin
        v = fwd_wdata[k*XLEN +: XLEN];
        p = fwd_pend[k];
      end
    end
  endfunction

  function automatic logic m_stallreq();
    logic [31:0] w, v1, v2;
    logic p1, p2;
    w = m_inst();
    m_resolve(w[25:21], rf_rdata1, v1, p1);
    m_resolve(w[20:16], rf_rdata2, v2, p2);
    return m_valid & (p1 | p2);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      m_sr = m_stallreq();
      if (cnt_clr) m_cnt = 0;
      else if (m_sr && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (stall[1] && !stall[2]) begin
        m_frozen = 1'b0; m_word = '0;
      end else if (m_frozen) begin
        if (!stall[2]) m_frozen = 1'b0;
      end else if (stall[2] && m_valid) begin
        m_frozen = 1'b1; m_word = inst_sram_rdata;
      end
      if (stall[1] && !stall[2]) begin
        m_valid = 1'b0; m_pc = '0;
      end else if (!stall[1]) begin
        m_valid = if_ce; m_pc = if_pc;
      end
    end
  end

  logic [31:0] e_inst, e1, e2;
  logic        ep1, ep2;

  always @(negedge clk) begin
    if (rst) model_reset();
    e_inst = m_inst();
    m_resolve(e_inst[25:21], rf_rdata1, e1, ep1);
    m_resolve(e_inst[20:16], rf_rdata2, e2, ep2);
    check("m_id_valid", 32'(id_valid), 32'(m_valid));
    check("m_id_pc", id_pc, m_pc);
    check("m_id_inst", id_inst, e_inst);
    check("m_raddr1", 32'(rf_raddr1), 32'(e_inst[25:21]));
    check("m_raddr2", 32'(rf_raddr2), 32'(e_inst[20:16]));
    check("m_src1", src1, e1);
    check("m_src2", src2, e2);
    check("m_stallreq", 32'(stallreq), 32'(m_valid & (ep1 | ep2)));
    check("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(id_valid), 32'h0);
    check({tag, "_pc"}, id_pc, 32'h0);
    check({tag, "_inst"}, id_inst, 32'h0);
    check({tag, "_stallreq"}, 32'(stallreq), 32'h0);
    check({tag, "_cnt"}, 32'(stall_cnt), 32'h0);
    check({tag, "_src1"}, src1, 32'h0);
    check({tag, "_src2"}, src2, 32'h0);
  endtask

  initial begin
    tick();
    check_reset_outputs("reset");

    // First fetch after reset
    rst = 1'b0; if_ce = 1'b1; if_pc = 32'hBFC00000; inst_sram_rdata = 32'h3C011234;
    tick();
    check("boot_valid", 32'(id_valid), 32'h1);
    check("boot_pc", id_pc, 32'hBFC00000);
    check("boot_inst", id_inst, 32'h3C011234);

    // Stall capture across three stalled edges
    stall = 6'b000110;
    tick();
    inst_sram_rdata = 32'hDEADBEEF;
    tick();
    check("hold1_inst", id_inst, 32'h3C011234);
    tick();
    check("hold2_inst", id_inst, 32'h3C011234);
    check("hold2_pc", id_pc, 32'hBFC00000);
    stall = '0; if_pc = 32'hBFC00004;
    #1;
    check("release_inst", id_inst, 32'h3C011234);
    check("release_pc", id_pc, 32'hBFC00000);
    tick();
    check("next_pc", id_pc, 32'hBFC00004);
    check("next_inst", id_inst, 32'hDEADBEEF);

    // Forwarding priority on rs=5
    inst_sram_rdata = 32'h00A00000; rf_rdata1 = 32'h0000AAAA;
    fwd_we = 3'b101; fwd_waddr = {5'd5, 5'd9, 5'd5};
    fwd_wdata = {32'h33, 32'h22, 32'h11};
    #1; check("fwd_young", src1, 32'h11);
    fwd_we = 3'b100;
    #1; check("fwd_old", src1, 32'h33);
    fwd_we = 3'b000;
    #1; check("fwd_rf", src1, 32'h0000AAAA);
    inst_sram_rdata = 32'h0; fwd_we = 3'b111; fwd_waddr = '0;
    #1; check("fwd_r0_src1", src1, 32'h0);
    check("fwd_r0_src2", src2, 32'h0);
    tick();

    // Load-use on rt=7
    inst_sram_rdata = 32'h00070000; fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd7};
    fwd_pend = 3'b001; cnt_clr = 1'b1;
    tick();
    check("lu_cnt_clr", 32'(stall_cnt), 32'h0);
    cnt_clr = 1'b0;
    #1; check("lu_stallreq", 32'(stallreq), 32'h1);
    tick();
    check("lu_cnt_inc", 32'(stall_cnt), 32'h1);
    fwd_we = 3'b011; fwd_waddr = {5'd0, 5'd7, 5'd7}; fwd_pend = 3'b010;
    #1; check("lu_masked", 32'(stallreq), 32'h0);
    check("lu_masked_src2", src2, 32'h11);

    // Bubble suppresses the interlock
    fwd_we = 3'b001; fwd_waddr = {5'd0, 5'd0, 5'd7}; fwd_pend = 3'b001;
    stall = 6'b000010;
    tick();
    check("bub_valid", 32'(id_valid), 32'h0);
    check("bub_inst", id_inst, 32'h0);
    check("bub_stallreq", 32'(stallreq), 32'h0);

    // Saturation of the 4-bit counter
    stall = '0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    repeat (20) tick();
    check("cnt_sat", 32'(stall_cnt), 32'hF);
    cnt_clr = 1'b1;
    tick();
    check("cnt_clr_prio", 32'(stall_cnt), 32'h0);
    cnt_clr = 1'b0;

    // Asynchronous reset while holding
    stall = 6'b000110;
    tick();
    check("pre_rst_cnt", 32'(stall_cnt), 32'h1);
    check("pre_rst_inst", id_inst, 32'h00070000);
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    tick();
    rst = 1'b0; stall = '0;

    // Randomized run against the model
    repeat (500) begin
      stall = 6'($urandom);
      stall[1] = ($urandom_range(0, 3) == 0);
      stall[2] = ($urandom_range(0, 3) == 0);
      if_ce = 1'($urandom);
      if_pc = $urandom;
      inst_sram_rdata = $urandom;
      inst_sram_rdata[25:21] = 5'($urandom_range(0, 7));
      inst_sram_rdata[20:16] = 5'($urandom_range(0, 7));
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      fwd_we = 3'($urandom);
      for (int k = 0; k < NUM_FWD; k++) begin
        fwd_waddr[k*RA_W +: RA_W] = 5'($urandom_range(0, 7));
        fwd_wdata[k*XLEN +: XLEN] = $urandom;
        fwd_pend[k] = ($urandom_range(0, 3) == 0);
      end
      cnt_clr = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
